// File: rtl/dmem_bridge.sv
// Data-side memory bridge: word RAM plus a memory-mapped camera pixel FIFO.
// Optional DMEM_CAM_IRQ_EN adds a THRESH register (0x14) and a registered cam_irq output.
module dmem_bridge #(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 16,
   parameter int PIX_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_enable,
   input  logic [31:0]      ALUResult,
   input  logic [31:0]      WriteData,
   output logic [31:0]      ReadData,
   input  logic             cam_valid,
   input  logic [PIX_W-1:0] cam_pixel,
   input  logic             cam_sof,
   output logic             cam_ready
`ifdef DMEM_CAM_IRQ_EN
  ,output logic             cam_irq
`endif
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_DATA   = 8'h04;
   localparam logic [7:0] OFF_POP    = 8'h08;
   localparam logic [7:0] OFF_CTRL   = 8'h0C;
   localparam logic [7:0] OFF_FRAME  = 8'h10;
   localparam logic [7:0] OFF_THRESH = 8'h14;

   logic [31:0]      ram [RAM_WORDS];
   logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          capture_en;
   logic          overflow;
   logic [15:0]   frame_cnt;

   logic          mmio_sel;
   logic [7:0]    offset;
   logic [AW-1:0] ram_idx;
   logic          full, empty;
   logic          pop_wr, ctrl_wr, pop, push, flush, ovf_evt, ovf_clr;
   logic [PIX_W-1:0] head;
   logic [7:0]    count8;
   logic          unused_addr;

   assign mmio_sel    = (ALUResult[31:16] == 16'hFFFF);
   assign offset      = ALUResult[7:0];
   assign ram_idx     = ALUResult[AW+1:2];
   assign unused_addr = ^ALUResult;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign count8  = 8'(count);
   assign head    = empty ? '0 : fifo_mem[rd_ptr];

   // cam_* handshake: a beat transfers on a rising edge where cam_valid and
   // cam_ready are both high; a valid beat offered while capture is enabled but
   // the FIFO is full is dropped (not stalled) and marks overflow.
   assign cam_ready = capture_en && !full;
   assign push      = cam_valid && cam_ready;
   assign ovf_evt   = cam_valid && capture_en && full;

   assign pop_wr  = write_enable && mmio_sel && (offset == OFF_POP);
   assign ctrl_wr = write_enable && mmio_sel && (offset == OFF_CTRL);
   assign pop     = pop_wr && !empty;
   assign flush   = ctrl_wr && WriteData[2];
   assign ovf_clr = ctrl_wr && WriteData[1];

   always_ff @(posedge clk) begin
      if (write_enable && !mmio_sel)
         ram[ram_idx] <= WriteData;
      if (push && !flush)
         fifo_mem[wr_ptr] <= cam_pixel;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         capture_en <= 1'b0;
         overflow   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         // Flush wins over any concurrent push or pop.
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (ctrl_wr)
            capture_en <= WriteData[0];
         // A new overflow in the same cycle as a clear keeps the flag set.
         if (ovf_evt)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
         if (push && cam_sof)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end

`ifdef DMEM_CAM_IRQ_EN
   logic [7:0] thresh;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thresh  <= '0;
         cam_irq <= 1'b0;
      end else begin
         if (write_enable && mmio_sel && (offset == OFF_THRESH))
            thresh <= WriteData[7:0];
         cam_irq <= ((32'(count) >= 32'(thresh)) && (thresh != 8'd0)) || overflow;
      end
   end
`endif

   always_comb begin
      ReadData = 32'd0;
      if (mmio_sel) begin
         case (offset)
            OFF_STATUS: ReadData = {16'd0, count8, 5'd0, overflow, full, !empty};
            OFF_DATA:   ReadData = 32'(head);
            OFF_CTRL:   ReadData = {31'd0, capture_en};
            OFF_FRAME:  ReadData = {16'd0, frame_cnt};
`ifdef DMEM_CAM_IRQ_EN
            OFF_THRESH: ReadData = {24'd0, thresh};
`endif
            default:    ReadData = 32'd0;
         endcase
      end else begin
         ReadData = ram[ram_idx];
      end
   end

endmodule
